// File: rtl/sobolcnt_mc_pkg.sv
// sobolcnt_mc_pkg: shared definitions for the multi-channel Sobol index counter.
// Holds the default counter width, the boundary mode constants, the LSZ index
// width derivation and the per-channel step encoding.
package sobolcnt_mc_pkg;

    localparam int SOBOLCNT_BITWIDTH = 8;

    // Boundary modes for the SAT parameter.
    localparam int SOBOLCNT_WRAP = 0;
    localparam int SOBOLCNT_SAT  = 1;

    // LSZ index must represent 0..bitwidth inclusive (bitwidth = all-ones count).
    function automatic int sobolcnt_idxw(input int bitwidth);
        return $clog2(bitwidth) + 1;
    endfunction

    // What a channel does on the coming edge, after priority resolution.
    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_CLR,
        STEP_LOAD,
        STEP_UP,
        STEP_DOWN
    } step_e;

endpackage

// File: rtl/sobolcnt_mc_lszdet.sv
// lszdet: combinational least-significant-zero detector.
// Returns the bit position of the lowest 0 in iCnt, or BITWIDTH when iCnt is
// all ones. Only compiled when SOBOLCNT_LSZ_EN is defined; without the macro
// the counter builds no LSZ logic at all.
`ifdef SOBOLCNT_LSZ_EN
module lszdet
    import sobolcnt_mc_pkg::*;
#(
    parameter int  BITWIDTH = SOBOLCNT_BITWIDTH,
    localparam int IDXW     = sobolcnt_idxw(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0] iCnt,
    output logic [IDXW-1:0]     oIdx
);

    // Scan from MSB down so the lowest zero bit is the last one to win.
    always_comb begin
        oIdx = IDXW'(BITWIDTH);
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!iCnt[i]) begin
                oIdx = IDXW'(i);
            end
        end
    end

endmodule
`endif

// File: rtl/sobolcnt_mc.sv
// sobolcnt_mc: NCH independent up/down index counters for the Sobol RNG datapath.
// Per channel: clear > load > enabled step > hold, wrap or saturate at the
// boundary, registered terminal-count pulse and registered LSZ index.
// Build option: SOBOLCNT_LSZ_EN builds the LSZ detectors and index registers;
// without it oLszIdx is tied to zero.
module sobolcnt_mc
    import sobolcnt_mc_pkg::*;
#(
    parameter int  BITWIDTH = SOBOLCNT_BITWIDTH,
    parameter int  NCH      = 4,
    parameter int  SAT      = SOBOLCNT_WRAP,
    localparam int IDXW     = sobolcnt_idxw(BITWIDTH)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iClr,
    input  logic [NCH-1:0]          iEn,
    input  logic [NCH-1:0]          iDn,
    input  logic [NCH-1:0]          iLd,
    input  logic [BITWIDTH-1:0]     iLdVal,
    output logic [NCH*BITWIDTH-1:0] oCnt,
    output logic [NCH-1:0]          oTc,
    output logic [NCH*IDXW-1:0]     oLszIdx
);

    localparam bit                SATURATE = (SAT == SOBOLCNT_SAT);
    localparam logic [BITWIDTH-1:0] ONE    = BITWIDTH'(1);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        step_e               step;
        logic [BITWIDTH-1:0] cnt_q, cnt_d;
        logic                tc_q, tc_d;
        logic                at_bound;

        // Resolve this channel's action from the shared clear and its own controls.
        always_comb begin
            if (iClr) begin
                step = STEP_CLR;
            end else if (iLd[g]) begin
                step = STEP_LOAD;
            end else if (iEn[g]) begin
                step = iDn[g] ? STEP_DOWN : STEP_UP;
            end else begin
                step = STEP_HOLD;
            end
        end

        // Next count and terminal-count; a step at the boundary flags tc and
        // either wraps naturally or is blocked in saturate mode.
        always_comb begin
            cnt_d    = cnt_q;
            tc_d     = 1'b0;
            at_bound = 1'b0;
            unique case (step)
                STEP_CLR:  cnt_d = '0;
                STEP_LOAD: cnt_d = iLdVal;
                STEP_UP: begin
                    at_bound = &cnt_q;
                    tc_d     = at_bound;
                    if (!(at_bound && SATURATE)) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                STEP_DOWN: begin
                    at_bound = ~|cnt_q;
                    tc_d     = at_bound;
                    if (!(at_bound && SATURATE)) begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: ;
            endcase
        end

        // Count and terminal-count registers.
        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
            end
        end

        assign oCnt[g*BITWIDTH +: BITWIDTH] = cnt_q;
        assign oTc[g]                       = tc_q;

`ifdef SOBOLCNT_LSZ_EN
        logic [IDXW-1:0] lsz_d, lsz_q;

        // Detect on the next count so the registered index lines up with oCnt.
        lszdet #(
            .BITWIDTH (BITWIDTH)
        ) u_lszdet (
            .iCnt (cnt_d),
            .oIdx (lsz_d)
        );

        // LSZ index register.
        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                lsz_q <= '0;
            end else begin
                lsz_q <= lsz_d;
            end
        end

        assign oLszIdx[g*IDXW +: IDXW] = lsz_q;
`else
        assign oLszIdx[g*IDXW +: IDXW] = '0;
`endif
    end

endmodule

// File: tb/tb_sobolcnt_mc.sv
// tb_sobolcnt_mc: drives a wrap-mode and a saturate-mode counter with the same
// stimulus and checks both against a behavioural model every cycle, plus a few
// literal expectations from directed scenarios.
module tb_sobolcnt_mc;

    localparam int BW   = 8;
    localparam int N    = 4;
    localparam int IW   = $clog2(BW) + 1;
    localparam int MAXV = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [N-1:0]  en, dn, ld;
    logic [BW-1:0] ldval;

    logic [N*BW-1:0] cnt_o [2];
    logic [N-1:0]    tc_o  [2];
    logic [N*IW-1:0] lsz_o [2];

    sobolcnt_mc #(.BITWIDTH(BW), .NCH(N), .SAT(0)) u_wrap (
        .iClk(clk), .iRst(rst), .iClr(clr), .iEn(en), .iDn(dn), .iLd(ld),
        .iLdVal(ldval), .oCnt(cnt_o[0]), .oTc(tc_o[0]), .oLszIdx(lsz_o[0])
    );

    sobolcnt_mc #(.BITWIDTH(BW), .NCH(N), .SAT(1)) u_sat (
        .iClk(clk), .iRst(rst), .iClr(clr), .iEn(en), .iDn(dn), .iLd(ld),
        .iLdVal(ldval), .oCnt(cnt_o[1]), .oTc(tc_o[1]), .oLszIdx(lsz_o[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = wrap instance, 1 = saturate instance.
    int mcnt [2][N];
    int mtc  [2][N];

    function automatic int lsz_of(input int v);
        for (int i = 0; i < BW; i++) begin
            if (((v >> i) & 1) == 0) return i;
        end
        return BW;
    endfunction

    function automatic int exp_lsz(input int v);
`ifdef SOBOLCNT_LSZ_EN
        return lsz_of(v);
`else
        return 0 * v;
`endif
    endfunction

    function automatic int dut_cnt(input int d, input int k);
        return int'(cnt_o[d][k*BW +: BW]);
    endfunction

    function automatic int dut_tc(input int d, input int k);
        return int'(tc_o[d][k]);
    endfunction

    function automatic int dut_lsz(input int d, input int k);
        return int'(lsz_o[d][k*IW +: IW]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain arithmetic on integer counts.
    always @(posedge clk or posedge rst) begin
        int nxt;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    mcnt[d][k] = 0;
                    mtc[d][k]  = 0;
                end else if (clr) begin
                    mcnt[d][k] = 0;
                    mtc[d][k]  = 0;
                end else if (ld[k]) begin
                    mcnt[d][k] = int'(ldval);
                    mtc[d][k]  = 0;
                end else if (en[k]) begin
                    nxt = dn[k] ? mcnt[d][k] - 1 : mcnt[d][k] + 1;
                    if (nxt < 0 || nxt > MAXV) begin
                        mtc[d][k] = 1;
                        if (d == 0) mcnt[d][k] = (nxt + MAXV + 1) % (MAXV + 1);
                    end else begin
                        mtc[d][k]  = 0;
                        mcnt[d][k] = nxt;
                    end
                end else begin
                    mtc[d][k] = 0;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("cnt[%0d][%0d]", d, k), dut_cnt(d, k), mcnt[d][k]);
                check($sformatf("tc[%0d][%0d]", d, k),  dut_tc(d, k),  mtc[d][k]);
                check($sformatf("lsz[%0d][%0d]", d, k), dut_lsz(d, k), exp_lsz(mcnt[d][k]));
            end
        end
    end

    task automatic cyc(input bit c, input logic [N-1:0] e, input logic [N-1:0] d,
                       input logic [N-1:0] l, input logic [BW-1:0] v);
        clr = c; en = e; dn = d; ld = l; ldval = v;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = '1; dn = '0; ld = '0; ldval = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_cnt", dut_cnt(0, k), 0);
            check("rst_tc",  dut_tc(0, k),  0);
            check("rst_lsz", dut_lsz(0, k), 0);
        end
        rst = 1'b0;

        // Count ch0 up three times.
        repeat (3) cyc(0, 4'b0001, 4'b0000, 4'b0000, 8'd0);
        check("up3_cnt0", dut_cnt(0, 0), 3);
        check("up3_lsz0", dut_lsz(0, 0), exp_lsz(3));
        check("up3_cnt1", dut_cnt(0, 1), 0);

        // Up wrap on ch1.
        cyc(0, 4'b0000, 4'b0000, 4'b0010, 8'd254);
        cyc(0, 4'b0010, 4'b0000, 4'b0000, 8'd0);
        check("wrap_255", dut_cnt(0, 1), 255);
        check("wrap_tc_at_255", dut_tc(0, 1), 0);
`ifdef SOBOLCNT_LSZ_EN
        check("wrap_lsz_255", dut_lsz(0, 1), 8);
`else
        check("wrap_lsz_255_off", dut_lsz(0, 1), 0);
`endif
        cyc(0, 4'b0010, 4'b0000, 4'b0000, 8'd0);
        check("wrap_0", dut_cnt(0, 1), 0);
        check("wrap_tc", dut_tc(0, 1), 1);
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 8'd0);
        check("wrap_tc_drop", dut_tc(0, 1), 0);

        // Down wrap on ch2.
        cyc(0, 4'b0100, 4'b0100, 4'b0000, 8'd0);
        check("dnwrap_cnt", dut_cnt(0, 2), 255);
        check("dnwrap_tc", dut_tc(0, 2), 1);
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 8'd0);
        check("dnwrap_tc_drop", dut_tc(0, 2), 0);

        // Saturate on ch3 of the SAT instance.
        cyc(0, 4'b0000, 4'b0000, 4'b1000, 8'd255);
        check("sat_load_tc", dut_tc(1, 3), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'b1000, 4'b0000, 4'b0000, 8'd0);
            check("sat_hold_cnt", dut_cnt(1, 3), 255);
            check("sat_hold_tc", dut_tc(1, 3), 1);
        end
        cyc(0, 4'b1000, 4'b1000, 4'b0000, 8'd0);
        check("sat_down_cnt", dut_cnt(1, 3), 254);
        check("sat_down_tc", dut_tc(1, 3), 0);

        // Priority: clear over load over enable, then load over enable.
        cyc(1, 4'b0001, 4'b0000, 4'b0001, 8'h55);
        check("prio_clr_cnt", dut_cnt(0, 0), 0);
        check("prio_clr_tc", dut_tc(0, 0), 0);
        cyc(0, 4'b0001, 4'b0000, 4'b0001, 8'h55);
        check("prio_ld_cnt", dut_cnt(0, 0), 8'h55);
        check("prio_ld_lsz", dut_lsz(0, 0), exp_lsz(8'h55));

        // Asynchronous reset mid-count.
        repeat (2) cyc(0, 4'b1111, 4'b0000, 4'b0000, 8'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt", dut_cnt(0, 0), 0);
        check("async_rst_tc", dut_tc(0, 2), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, biased towards boundary load values.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0]  l;
            logic [BW-1:0] v;
            for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: v = 8'd0;
                1: v = 8'd1;
                2: v = 8'd254;
                3: v = 8'd255;
                default: v = BW'($urandom);
            endcase
            cyc($urandom_range(0, 39) == 0, N'($urandom), N'($urandom), l, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
